// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response channel between the fetch unit (master)
// and the instruction memory (slave).
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (output imem_req, imem_addr,
                  input  imem_ready, imem_rvalid, imem_rdata);
  modport slave  (input  imem_req, imem_addr,
                  output imem_ready, imem_rvalid, imem_rdata);
endinterface

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch FSM that feeds the IF/ID register.
// A redirect kills any in-flight fetch and restarts fetching at the target.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall,
  input  logic         jal,
  input  logic         jalr,
  input  logic         branch_result,
  input  logic [31:0]  target_address,
  fetch_unit_if.master imem,
  output logic [31:0]  instruction_fetch,
  output logic [31:0]  pc_pre_address,
  output logic         fetch_valid
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DROP} state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic [31:0] pc_pre_q;
  logic        fv_q;

  logic        redirect;
  logic [31:0] redir_pc;
  logic [31:0] pc_inc;

  assign redirect = jal | jalr | branch_result;
  assign redir_pc = {target_address[31:2], 2'b00};
  assign pc_inc   = pc_q + 32'd4;

  assign imem.imem_req  = (state_q == REQ);
  assign imem.imem_addr = pc_q;

  assign instruction_fetch = instr_q;
  assign pc_pre_address    = pc_pre_q;
  assign fetch_valid       = fv_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      instr_q  <= '0;
      pc_pre_q <= '0;
      fv_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: state_q <= REQ;
        REQ: begin
          // An accepted request under redirect is already stale; drain it.
          if (redirect) begin
            pc_q <= redir_pc;
            if (imem.imem_ready) state_q <= DROP;
          end else if (imem.imem_ready) begin
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (imem.imem_rvalid) begin
            if (redirect) begin
              pc_q    <= redir_pc;
              state_q <= REQ;
            end else begin
              instr_q  <= imem.imem_rdata;
              pc_pre_q <= pc_q;
              pc_q     <= pc_inc;
              fv_q     <= 1'b1;
              state_q  <= HOLD;
            end
          end else if (redirect) begin
            pc_q    <= redir_pc;
            state_q <= DROP;
          end
        end
        HOLD: begin
          if (!stall || redirect) begin
            fv_q    <= 1'b0;
            state_q <= REQ;
            if (redirect) pc_q <= redir_pc;
          end
        end
        DROP: begin
          if (redirect) pc_q <= redir_pc;
          if (imem.imem_rvalid) state_q <= REQ;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run
// scored against an address-sequence model of the fetch stream.
module tb_fetch_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, rst2, stall, jal, jalr, branch_result;
  logic [31:0] target_address;
  logic [31:0] instr, pcp, instr2, pcp2;
  logic        fv, fv2;

  fetch_unit_if ifc ();
  fetch_unit_if ifc2 ();

  fetch_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .jal(jal), .jalr(jalr),
    .branch_result(branch_result), .target_address(target_address),
    .imem(ifc), .instruction_fetch(instr), .pc_pre_address(pcp),
    .fetch_valid(fv));

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .rst(rst2), .stall(stall), .jal(jal), .jalr(jalr),
    .branch_result(branch_result), .target_address(target_address),
    .imem(ifc2), .instruction_fetch(instr2), .pc_pre_address(pcp2),
    .fetch_valid(fv2));

  int errors = 0;
  int checks = 0;

  // Memory responder: data = addr ^ A5A5A5A5, latency lat_min..lat_max.
  localparam logic [31:0] KEY = 32'hA5A5_A5A5;
  bit          pend = 0;
  int          cnt = 0;
  logic [31:0] paddr = '0;
  int          lat_min = 1, lat_max = 1, ready_pct = 100;
  int          overlap = 0;

  always @(negedge clk) begin
    if (pend && cnt == 0) begin
      ifc.imem_rvalid = 1'b1;
      ifc.imem_rdata  = paddr ^ KEY;
      pend = 0;
    end else begin
      ifc.imem_rvalid = 1'b0;
      ifc.imem_rdata  = $urandom;
      if (pend) cnt--;
    end
    ifc.imem_ready = ($urandom_range(99) < ready_pct);
    if (ifc.imem_req === 1'b1 && ifc.imem_ready) begin
      if (pend) overlap++;
      else begin
        pend  = 1;
        paddr = ifc.imem_addr;
        cnt   = $urandom_range(lat_max, lat_min) - 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic reset_dut();
    rst = 1'b1; stall = 1'b0; jal = 1'b0; jalr = 1'b0; branch_result = 1'b0;
    repeat (5) tick();
    rst = 1'b0;
  endtask

  task automatic wait_req(input logic [31:0] addr, output bit ok);
    ok = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (ifc.imem_req === 1'b1 && ifc.imem_addr === addr) begin
        ok = 1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    ready_pct = 100; lat_min = 1; lat_max = 1;
    reset_dut();
    checks++;
    if (ifc.imem_req !== 1'b0 || fv !== 1'b0 || instr !== 32'h0 || pcp !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: req=%b fv=%b instr=%h pc=%h, need 0/0/0/0",
               ifc.imem_req, fv, instr, pcp);
    end
    tick();
    checks++;
    if (ifc.imem_req !== 1'b1 || ifc.imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL first_req: req=%b addr=%h, need 1/00000000", ifc.imem_req, ifc.imem_addr);
    end
  endtask

  task automatic test_sequence();
    int nreq = 0, nfv = 0, last = 0;
    logic prev = 1'b0;
    ready_pct = 100; lat_min = 1; lat_max = 1;
    reset_dut();
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (ifc.imem_req === 1'b1) begin
        checks++;
        if (ifc.imem_addr !== 32'(4 * nreq)) begin
          errors++;
          $display("FAIL seq_addr: got %h, need %h", ifc.imem_addr, 32'(4 * nreq));
        end
        if (nreq > 0) begin
          checks++;
          if (c - last != 3) begin
            errors++;
            $display("FAIL seq_rate: req spacing %0d, need 3", c - last);
          end
        end
        last = c;
        nreq++;
      end
      if (fv === 1'b1) begin
        checks++;
        if (prev || pcp !== 32'(4 * nfv) || instr !== (32'(4 * nfv) ^ KEY)) begin
          errors++;
          $display("FAIL seq_fetch: pc=%h instr=%h prev_fv=%b, need pc=%h instr=%h pulse",
                   pcp, instr, prev, 32'(4 * nfv), 32'(4 * nfv) ^ KEY);
        end
        nfv++;
      end
      prev = fv;
    end
    checks++;
    if (nfv < 3 || nreq < 3) begin
      errors++;
      $display("FAIL seq_count: fetches=%0d reqs=%0d, need >=3 each", nfv, nreq);
    end
  endtask

  task automatic test_stall();
    bit found = 0;
    ready_pct = 100; lat_min = 1; lat_max = 1;
    reset_dut();
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (fv === 1'b1 && pcp === 32'h4) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL stall_capture: no capture at pc 4, need one within 20 cycles");
    end
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (fv !== 1'b1 || pcp !== 32'h4 || instr !== (32'h4 ^ KEY) || ifc.imem_req !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold: fv=%b pc=%h instr=%h req=%b, need 1/4/%h/0",
                 fv, pcp, instr, ifc.imem_req, 32'h4 ^ KEY);
      end
    end
    stall = 1'b0;
    tick();
    checks++;
    if (fv !== 1'b0 || ifc.imem_req !== 1'b1 || ifc.imem_addr !== 32'h8) begin
      errors++;
      $display("FAIL stall_release: fv=%b req=%b addr=%h, need 0/1/8", fv, ifc.imem_req, ifc.imem_addr);
    end
  endtask

  task automatic test_jal_drop();
    bit ok, found = 0;
    ready_pct = 100; lat_min = 3; lat_max = 3;
    reset_dut();
    wait_req(32'h8, ok);
    tick();
    jal = 1'b1; target_address = 32'h0000_0103;
    tick();
    jal = 1'b0;
    checks++;
    if (!ok || fv !== 1'b0 || ifc.imem_req !== 1'b0) begin
      errors++;
      $display("FAIL jal_drop: reached=%b fv=%b req=%b, need 1/0/0", ok, fv, ifc.imem_req);
    end
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      checks++;
      if (fv !== 1'b0) begin
        errors++;
        $display("FAIL jal_discard: fv=%b pc=%h, need fv 0", fv, pcp);
      end
      if (ifc.imem_req === 1'b1) found = 1;
    end
    checks++;
    if (!found || ifc.imem_addr !== 32'h0000_0100) begin
      errors++;
      $display("FAIL jal_target: found=%b addr=%h, need 1/00000100", found, ifc.imem_addr);
    end
    lat_min = 1; lat_max = 1;
  endtask

  task automatic test_branch_same_cycle();
    bit ok, found = 0;
    ready_pct = 100; lat_min = 1; lat_max = 1;
    reset_dut();
    wait_req(32'h8, ok);
    tick();
    branch_result = 1'b1; target_address = 32'h0000_0040;
    tick();
    branch_result = 1'b0;
    checks++;
    if (!ok || fv !== 1'b0 || ifc.imem_req !== 1'b1 || ifc.imem_addr !== 32'h40) begin
      errors++;
      $display("FAIL branch_kill: reached=%b fv=%b req=%b addr=%h, need 1/0/1/40",
               ok, fv, ifc.imem_req, ifc.imem_addr);
    end
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (fv === 1'b1) found = 1;
    end
    checks++;
    if (!found || pcp !== 32'h40 || instr !== (32'h40 ^ KEY)) begin
      errors++;
      $display("FAIL branch_fetch: found=%b pc=%h instr=%h, need 1/40/%h", found, pcp, instr, 32'h40 ^ KEY);
    end
  endtask

  task automatic test_reset_inflight();
    bit ok, found = 0;
    ready_pct = 100; lat_min = 2; lat_max = 2;
    reset_dut();
    wait_req(32'h4, ok);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (!ok || ifc.imem_req !== 1'b0 || fv !== 1'b0 || instr !== 32'h0 || pcp !== 32'h0) begin
      errors++;
      $display("FAIL rst_wait: reached=%b req=%b fv=%b instr=%h pc=%h, need 1/0/0/0/0",
               ok, ifc.imem_req, fv, instr, pcp);
    end
    tick();
    checks++;
    if (ifc.imem_req !== 1'b1 || ifc.imem_addr !== 32'h0 || fv !== 1'b0) begin
      errors++;
      $display("FAIL rst_first_req: req=%b addr=%h fv=%b, need 1/0/0", ifc.imem_req, ifc.imem_addr, fv);
    end
    for (int i = 0; i < 12 && !found; i++) begin
      tick();
      if (fv === 1'b1) found = 1;
      else begin
        checks++;
        if (instr !== 32'h0 || pcp !== 32'h0) begin
          errors++;
          $display("FAIL rst_outputs: instr=%h pc=%h, need 0/0", instr, pcp);
        end
      end
    end
    checks++;
    if (!found || pcp !== 32'h0 || instr !== KEY) begin
      errors++;
      $display("FAIL rst_capture: found=%b pc=%h instr=%h, need 1/0/%h", found, pcp, instr, KEY);
    end
    lat_min = 1; lat_max = 1;
  endtask

  task automatic test_wrap();
    ifc2.imem_ready = 1'b1; ifc2.imem_rvalid = 1'b0; ifc2.imem_rdata = '0;
    rst2 = 1'b1;
    repeat (2) tick();
    rst2 = 1'b0;
    tick();
    checks++;
    if (ifc2.imem_req !== 1'b1 || ifc2.imem_addr !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL wrap_req: req=%b addr=%h, need 1/FFFFFFFC", ifc2.imem_req, ifc2.imem_addr);
    end
    tick();
    ifc2.imem_rvalid = 1'b1; ifc2.imem_rdata = 32'h1234_5678;
    tick();
    ifc2.imem_rvalid = 1'b0;
    checks++;
    if (fv2 !== 1'b1 || pcp2 !== 32'hFFFF_FFFC || instr2 !== 32'h1234_5678) begin
      errors++;
      $display("FAIL wrap_fetch: fv=%b pc=%h instr=%h, need 1/FFFFFFFC/12345678", fv2, pcp2, instr2);
    end
    tick();
    checks++;
    if (ifc2.imem_req !== 1'b1 || ifc2.imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL wrap_next: req=%b addr=%h, need 1/00000000", ifc2.imem_req, ifc2.imem_addr);
    end
    rst2 = 1'b1;
  endtask

  // Model: fetched PCs run sequentially from the last redirect target.
  task automatic test_random();
    logic [31:0] exp_pc = 32'h0;
    logic        prev = 1'b0;
    int          caps = 0;
    ready_pct = 60; lat_min = 1; lat_max = 3;
    overlap = 0;
    reset_dut();
    for (int i = 0; i < 600; i++) begin
      tick();
      jal = 1'b0; jalr = 1'b0; branch_result = 1'b0;
      if (fv === 1'b1 && !prev) begin
        checks++;
        if (pcp !== exp_pc || instr !== (exp_pc ^ KEY)) begin
          errors++;
          $display("FAIL rand_fetch: pc=%h instr=%h, need %h/%h", pcp, instr, exp_pc, exp_pc ^ KEY);
        end
        exp_pc = exp_pc + 32'd4;
        caps++;
      end
      prev = fv;
      if (ifc.imem_req === 1'b1) begin
        checks++;
        if (ifc.imem_addr !== exp_pc) begin
          errors++;
          $display("FAIL rand_addr: got %h, need %h", ifc.imem_addr, exp_pc);
        end
      end
      stall = ($urandom_range(3) == 0);
      if ($urandom_range(11) == 0) begin
        target_address = $urandom;
        case ($urandom_range(2))
          0: jal = 1'b1;
          1: jalr = 1'b1;
          default: branch_result = 1'b1;
        endcase
        exp_pc = {target_address[31:2], 2'b00};
      end
    end
    jal = 1'b0; jalr = 1'b0; branch_result = 1'b0; stall = 1'b0;
    checks++;
    if (caps < 20 || overlap != 0) begin
      errors++;
      $display("FAIL rand_progress: captures=%0d overlaps=%0d, need >=20/0", caps, overlap);
    end
  endtask

  initial begin
    ifc.imem_ready = 1'b0; ifc.imem_rvalid = 1'b0; ifc.imem_rdata = '0;
    ifc2.imem_ready = 1'b0; ifc2.imem_rvalid = 1'b0; ifc2.imem_rdata = '0;
    rst = 1'b1; rst2 = 1'b1; stall = 1'b0;
    jal = 1'b0; jalr = 1'b0; branch_result = 1'b0; target_address = '0;
    test_reset();
    test_sequence();
    test_stall();
    test_jal_drop();
    test_branch_same_cycle();
    test_reset_inflight();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter: RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] SHALL be 00.
REQ-002 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: stall  input  1  downstream hold; output word not consumed this cycle.
REQ-005 SHALL have ports: jal, jalr, branch_result  input  1 each  redirect qualifiers; redirect = jal|jalr|branch_result.
REQ-006 SHALL have port: target_address  input  32  redirect destination; sampled only when redirect=1.
REQ-007 SHALL have ports: imem_req  output  1, imem_addr  output  32  instruction memory request and word address.
REQ-008 SHALL have ports: imem_ready  input  1 (request accepted), imem_rvalid  input  1, imem_rdata  input  32 (response).
REQ-009 SHALL have ports: instruction_fetch  output  32, pc_pre_address  output  32, fetch_valid  output  1  fetched word, its PC, qualifier; feeds IF/ID register.

Function
REQ-010 SHALL implement states IDLE, REQ, WAIT, HOLD, DROP; at most one memory request outstanding.
REQ-011 IDLE: imem_req=0; next state REQ unconditionally.
REQ-012 REQ: imem_req=1, imem_addr=pc (combinational from state); imem_ready=1 and redirect=0 -> WAIT.
REQ-013 REQ with redirect=1: pc<=target_address; imem_ready=1 -> DROP (accepted request is stale), else stay REQ.
REQ-014 WAIT, imem_rvalid=1, redirect=0: instruction_fetch<=imem_rdata, pc_pre_address<=pc, pc<=pc+4, fetch_valid<=1, -> HOLD.
REQ-015 WAIT, imem_rvalid=1, redirect=1: response discarded, outputs unchanged, pc<=target_address, -> REQ.
REQ-016 WAIT, imem_rvalid=0, redirect=1: pc<=target_address, -> DROP.
REQ-017 DROP: next imem_rvalid discarded, -> REQ; redirect in DROP updates pc, stays DROP until that response.
REQ-018 HOLD: instruction_fetch, pc_pre_address, fetch_valid held while stall=1 and redirect=0.
REQ-019 HOLD, stall=0 or redirect=1: fetch_valid<=0, -> REQ; if redirect, pc<=target_address (redirect overrides stall).
REQ-020 imem_rvalid in IDLE, REQ or HOLD SHALL be ignored.
REQ-021 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-022 target_address[1:0] SHALL be forced to 00 when loaded into pc.
REQ-023 Throughput with single-cycle memory and no stall: one instruction per 3 cycles (REQ, WAIT, HOLD).
REQ-024 imem_req SHALL be 0 in IDLE, WAIT, HOLD, DROP.

Reset
REQ-025 rst=1 SHALL, next edge: pc<=RESET_PC, state<=IDLE, instruction_fetch<=0, pc_pre_address<=0, fetch_valid<=0.
REQ-026 rst SHALL override every other input in any state, including WAIT/DROP; an in-flight response arriving after reset release while in IDLE SHALL be ignored.
REQ-027 First imem_req SHALL assert in the second cycle after rst deasserts (IDLE then REQ).

Verification
REQ-028 Reset then imem_ready=1 always, rvalid one cycle after accept, rdata=addr^32'hA5A5_A5A5, stall=0 -> imem_addr 0,4,8; fetch_valid pulses one cycle each, pc_pre_address 0,4,8, instruction_fetch 32'hA5A5_A5A5, 32'hA5A5_A5A1, 32'hA5A5_A5AD.
REQ-029 Capture at pc=4, hold stall=1 three cycles -> instruction_fetch, pc_pre_address=4, fetch_valid=1 stable; no imem_req; stall=0 -> fetch_valid=0, next imem_addr=8.
REQ-030 In WAIT (addr 8), jal=1 with target_address=32'h0000_0103, rvalid=0 -> DROP; next rvalid discarded (fetch_valid stays 0); next imem_addr=32'h0000_0100.
REQ-031 In WAIT, branch_result=1 same cycle as rvalid, target 32'h40 -> no fetch_valid, next imem_addr=32'h40.
REQ-032 RESET_PC=32'hFFFF_FFFC, one fetch -> pc_pre_address=32'hFFFF_FFFC, next imem_addr=0.
REQ-033 rst=1 during WAIT, late rvalid arrives while in IDLE -> discarded; first imem_addr=RESET_PC, all outputs 0 until first capture.
